sru_step_scheduler: RTL and testbench

Per-time-step sequencer for the synaptic response unit (SRU) trace datapath. On each `step_start` it latches the presynaptic spike vector. It then scans every input's weight from the synaptic weight memory and accumulates separate saturating excitatory and inhibitory weight sums. Finally it issues exactly two update beats to the SRU: one excitatory (`Ein=1`), one inhibitory (`Ein=0`). This guarantees one decay per trace per time step regardless of spike count.

---
 rtl/sru_pkg.sv | 16 +
 rtl/sru_sat_acc.sv | 39 +++
 rtl/sru_step_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_sru_step_scheduler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sru_pkg.sv
// Shared SRU definitions: scheduler FSM encoding and datapath widths common
// to the step scheduler and the trace unit.
package sru_pkg;

  localparam int unsigned SRU_W_WIDTH      = 16;
  localparam int unsigned SRU_N_INPUTS_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SCAN    = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_ISSUE_E = 3'd3,
    ST_ISSUE_I = 3'd4
  } sru_sched_state_t;

endpackage : sru_pkg

// File: rtl/sru_sat_acc.sv
// Unsigned saturating accumulator with synchronous clear. It exposes its
// next value so the owner can register a result in the same cycle it settles.
module sru_sat_acc #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] add,
  output logic [W-1:0] sum,
  output logic [W-1:0] sum_nxt_c,
  output logic         ovf_c
);

  logic [W:0] raw_c;

  // Clear wins over enable; a carry out clamps to all-ones.
  always_comb begin
    raw_c     = {1'b0, sum} + {1'b0, add};
    sum_nxt_c = sum;
    ovf_c     = 1'b0;
    if (clr) begin
      sum_nxt_c = '0;
    end else if (en) begin
      ovf_c     = raw_c[W];
      sum_nxt_c = raw_c[W] ? {W{1'b1}} : raw_c[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum <= '0;
    end else begin
      sum <= sum_nxt_c;
    end
  end

endmodule : sru_sat_acc

// File: rtl/sru_step_scheduler.sv
// Per-time-step sequencer: scans the weight memory for spiking inputs and
// emits exactly one excitatory and one inhibitory update beat to the SRU.
module sru_step_scheduler
  import sru_pkg::*;
#(
  parameter int unsigned N_INPUTS = SRU_N_INPUTS_DEF,
  parameter int unsigned IDX_W    = $clog2(N_INPUTS),
  parameter int unsigned W_WIDTH  = SRU_W_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                step_start,
  input  logic [N_INPUTS-1:0] spike_vec,
  input  logic [N_INPUTS-1:0] exc_mask,
  output logic [IDX_W-1:0]    wt_addr,
  input  logic [W_WIDTH-1:0]  wt_data,
  output logic                upd_valid,
  output logic                E_plus,
  output logic                Ein,
  output logic [W_WIDTH-1:0]  wi,
  output logic                busy,
  output logic                step_done,
  output logic                overrun,
  output logic                sat
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

  sru_sched_state_t state, state_nxt;

  logic [IDX_W-1:0]    idx;
  logic [N_INPUTS-1:0] spk_lat;
  logic [N_INPUTS-1:0] exc_lat;
  logic                exc_any;
  logic                inh_any;

  logic                accept_c;
  logic                acc_en_c;
  logic [IDX_W-1:0]    acc_idx_c;
  logic                exc_hit_c;
  logic                inh_hit_c;

  logic [W_WIDTH-1:0]  exc_sum, exc_sum_nxt_c;
  logic [W_WIDTH-1:0]  inh_sum, inh_sum_nxt_c;
  logic                exc_ovf_c, inh_ovf_c;

  logic                upd_valid_d;
  logic                e_plus_d;
  logic                ein_d;
  logic [W_WIDTH-1:0]  wi_d;
  logic                busy_d;
  logic                step_done_d;

  assign wt_addr = idx;

  // Read data lags the address by one cycle, so SCAN accumulates idx-1 and
  // DRAIN picks up the final input while the address is parked on it.
  always_comb begin
    accept_c  = (state == ST_IDLE) && step_start;
    acc_en_c  = ((state == ST_SCAN) && (idx != '0)) || (state == ST_DRAIN);
    acc_idx_c = (state == ST_DRAIN) ? idx : (idx - IDX_W'(1));
    exc_hit_c = acc_en_c && spk_lat[acc_idx_c] && exc_lat[acc_idx_c];
    inh_hit_c = acc_en_c && spk_lat[acc_idx_c] && !exc_lat[acc_idx_c];
  end

  sru_sat_acc #(.W(W_WIDTH)) u_exc_acc (
    .clk       (clk),
    .reset     (reset),
    .clr       (accept_c),
    .en        (exc_hit_c),
    .add       (wt_data),
    .sum       (exc_sum),
    .sum_nxt_c (exc_sum_nxt_c),
    .ovf_c     (exc_ovf_c)
  );

  sru_sat_acc #(.W(W_WIDTH)) u_inh_acc (
    .clk       (clk),
    .reset     (reset),
    .clr       (accept_c),
    .en        (inh_hit_c),
    .add       (wt_data),
    .sum       (inh_sum),
    .sum_nxt_c (inh_sum_nxt_c),
    .ovf_c     (inh_ovf_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (step_start) state_nxt = ST_SCAN;
      ST_SCAN:    if (idx == IDX_LAST) state_nxt = ST_DRAIN;
      ST_DRAIN:   state_nxt = ST_ISSUE_E;
      ST_ISSUE_E: state_nxt = ST_ISSUE_I;
      ST_ISSUE_I: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each beat
  // lines up with the state it belongs to. Ein/wi hold between beats.
  always_comb begin
    upd_valid_d = 1'b0;
    e_plus_d    = 1'b0;
    ein_d       = Ein;
    wi_d        = wi;
    busy_d      = (state_nxt != ST_IDLE);
    step_done_d = 1'b0;
    unique case (state_nxt)
      ST_ISSUE_E: begin
        upd_valid_d = 1'b1;
        ein_d       = 1'b1;
        e_plus_d    = exc_any | exc_hit_c;
        wi_d        = exc_sum_nxt_c;
      end
      ST_ISSUE_I: begin
        upd_valid_d = 1'b1;
        ein_d       = 1'b0;
        e_plus_d    = inh_any | inh_hit_c;
        wi_d        = inh_sum_nxt_c;
        step_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_valid <= 1'b0;
      E_plus    <= 1'b0;
      Ein       <= 1'b0;
      wi        <= '0;
      busy      <= 1'b0;
      step_done <= 1'b0;
    end else begin
      upd_valid <= upd_valid_d;
      E_plus    <= e_plus_d;
      Ein       <= ein_d;
      wi        <= wi_d;
      busy      <= busy_d;
      step_done <= step_done_d;
    end
  end

  // Step context: latched vectors, scan index and per-step flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx     <= '0;
      spk_lat <= '0;
      exc_lat <= '0;
      exc_any <= 1'b0;
      inh_any <= 1'b0;
      sat     <= 1'b0;
      overrun <= 1'b0;
    end else if (accept_c) begin
      idx     <= '0;
      spk_lat <= spike_vec;
      exc_lat <= exc_mask;
      exc_any <= 1'b0;
      inh_any <= 1'b0;
      sat     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if ((state == ST_SCAN) && (idx != IDX_LAST)) begin
        idx <= idx + IDX_W'(1);
      end
      exc_any <= exc_any | exc_hit_c;
      inh_any <= inh_any | inh_hit_c;
      sat     <= sat | exc_ovf_c | inh_ovf_c;
      if (step_start) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule : sru_step_scheduler

// File: tb/tb_sru_step_scheduler.sv
// Directed bench for sru_step_scheduler with a one-cycle-latency weight memory.
module tb_sru_step_scheduler;

  logic        clk;
  logic        reset;
  logic        step_start;
  logic [15:0] spike_vec;
  logic [15:0] exc_mask;
  logic [3:0]  wt_addr;
  logic [15:0] wt_data;
  logic        upd_valid;
  logic        E_plus;
  logic        Ein;
  logic [15:0] wi;
  logic        busy;
  logic        step_done;
  logic        overrun;
  logic        sat;

  logic [15:0] wmem [16];
  int          n_chk;
  int          n_bad;
  int          cur;

  sru_step_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .step_start (step_start),
    .spike_vec  (spike_vec),
    .exc_mask   (exc_mask),
    .wt_addr    (wt_addr),
    .wt_data    (wt_data),
    .upd_valid  (upd_valid),
    .E_plus     (E_plus),
    .Ein        (Ein),
    .wi         (wi),
    .busy       (busy),
    .step_done  (step_done),
    .overrun    (overrun),
    .sat        (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) wt_data <= wmem[wt_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, exp, cur);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cur++;
    end
  endtask

  task automatic fill_w(input logic [15:0] v);
    for (int i = 0; i < 16; i++) wmem[i] = v;
  endtask

  task automatic launch(input logic [15:0] spk, input logic [15:0] exc);
    spike_vec  = spk;
    exc_mask   = exc;
    step_start = 1'b1;
    adv(1);
    step_start = 1'b0;
    cur        = 1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(upd_valid), 32'd0);
    chk({tag, "_eplus"}, 32'(E_plus), 32'd0);
    chk({tag, "_ein"},   32'(Ein), 32'd0);
    chk({tag, "_wi"},    32'(wi), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(step_done), 32'd0);
    chk({tag, "_ovr"},   32'(overrun), 32'd0);
    chk({tag, "_sat"},   32'(sat), 32'd0);
    chk({tag, "_addr"},  32'(wt_addr), 32'd0);
  endtask

  // Checks cycles 17..19 of a step; returns positioned in cycle 19.
  task automatic chk_beats(input string tag, input logic ee, input logic [15:0] ew,
                           input logic ie, input logic [15:0] iw, input logic s);
    adv(17 - cur);
    chk({tag, "_drain_valid"}, 32'(upd_valid), 32'd0);
    chk({tag, "_drain_busy"},  32'(busy), 32'd1);
    adv(1);
    chk({tag, "_e_valid"}, 32'(upd_valid), 32'd1);
    chk({tag, "_e_ein"},   32'(Ein), 32'd1);
    chk({tag, "_e_eplus"}, 32'(E_plus), 32'(ee));
    chk({tag, "_e_wi"},    32'(wi), 32'(ew));
    chk({tag, "_e_done"},  32'(step_done), 32'd0);
    adv(1);
    chk({tag, "_i_valid"}, 32'(upd_valid), 32'd1);
    chk({tag, "_i_ein"},   32'(Ein), 32'd0);
    chk({tag, "_i_eplus"}, 32'(E_plus), 32'(ie));
    chk({tag, "_i_wi"},    32'(wi), 32'(iw));
    chk({tag, "_i_done"},  32'(step_done), 32'd1);
    chk({tag, "_i_busy"},  32'(busy), 32'd1);
    chk({tag, "_sat"},     32'(sat), 32'(s));
  endtask

  task automatic chk_idle(input string tag, input logic [15:0] iw);
    adv(1);
    chk({tag, "_idle_busy"},  32'(busy), 32'd0);
    chk({tag, "_idle_valid"}, 32'(upd_valid), 32'd0);
    chk({tag, "_idle_eplus"}, 32'(E_plus), 32'd0);
    chk({tag, "_idle_wi"},    32'(wi), 32'(iw));
  endtask

  initial begin
    logic seen_valid;
    n_chk      = 0;
    n_bad      = 0;
    cur        = 0;
    reset      = 1'b0;
    step_start = 1'b0;
    spike_vec  = '0;
    exc_mask   = '0;
    fill_w(16'h0000);
    adv(2);
    chk_all_zero("reset");
    reset = 1'b1;
    adv(1);

    // Single excitatory spike; non-spiking weights must be ignored.
    fill_w(16'h5555);
    wmem[0] = 16'h0010;
    launch(16'h0001, 16'hFFFF);
    chk("single_busy_c1", 32'(busy), 32'd1);
    chk("single_addr_c1", 32'(wt_addr), 32'd0);
    adv(4);
    chk("single_addr_c5", 32'(wt_addr), 32'd4);
    chk_beats("single", 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0);
    chk_idle("single", 16'h0000);

    // Mixed excitatory/inhibitory spikes.
    fill_w(16'h0000);
    wmem[0] = 16'h0010;
    wmem[3] = 16'h0020;
    wmem[5] = 16'h0100;
    wmem[6] = 16'h7777;
    launch(16'h0029, 16'hFF9F);
    chk_beats("mixed", 1'b1, 16'h0030, 1'b1, 16'h0100, 1'b0);
    chk_idle("mixed", 16'h0100);

    // No spikes: decay-only beats.
    fill_w(16'hFFFF);
    launch(16'h0000, 16'h00FF);
    chk_beats("nospk", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    chk_idle("nospk", 16'h0000);

    // Zero-weight inhibitory spike still asserts E_plus.
    fill_w(16'h0000);
    launch(16'h0004, 16'h0000);
    chk_beats("zerow", 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0);
    chk_idle("zerow", 16'h0000);

    // Excitatory saturation.
    fill_w(16'h2000);
    launch(16'hFFFF, 16'hFFFF);
    chk_beats("satur", 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b1);
    chk_idle("satur", 16'h0000);

    // Overrun: stray starts at cycle 5 and in ISSUE_I, accepted at cycle 20.
    fill_w(16'h0000);
    wmem[0] = 16'h0010;
    wmem[3] = 16'h0020;
    wmem[5] = 16'h0100;
    wmem[6] = 16'h7777;
    launch(16'h0029, 16'hFF9F);
    chk("ovr_pre", 32'(overrun), 32'd0);
    adv(4);
    spike_vec  = 16'hFFFF;
    exc_mask   = 16'h0000;
    step_start = 1'b1;
    adv(1);
    step_start = 1'b0;
    chk("ovr_set_c6", 32'(overrun), 32'd1);
    chk("ovr_busy_c6", 32'(busy), 32'd1);
    chk_beats("ovr_a", 1'b1, 16'h0030, 1'b1, 16'h0100, 1'b0);
    spike_vec  = 16'h0060;
    exc_mask   = 16'h0000;
    step_start = 1'b1;
    adv(1);
    chk("ovr_hold_c20", 32'(overrun), 32'd1);
    chk("ovr_idle_c20", 32'(busy), 32'd0);
    chk("ovr_nobeat_c20", 32'(upd_valid), 32'd0);
    adv(1);
    step_start = 1'b0;
    cur        = 1;
    chk("ovr_clear", 32'(overrun), 32'd0);
    chk("ovr_new_busy", 32'(busy), 32'd1);
    chk_beats("ovr_b", 1'b0, 16'h0000, 1'b1, 16'h7877, 1'b0);
    chk_idle("ovr_b", 16'h7877);

    // Reset mid-step after saturation has already been flagged.
    fill_w(16'h2000);
    launch(16'hFFFF, 16'hFFFF);
    adv(9);
    chk("rst_pre_sat", 32'(sat), 32'd1);
    chk("rst_pre_addr", 32'(wt_addr), 32'd9);
    reset = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    adv(3);
    reset = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      adv(1);
      if (upd_valid || busy) seen_valid = 1'b1;
    end
    chk("rst_no_beat", 32'(seen_valid), 32'd0);

    // Recovery after reset.
    fill_w(16'h0003);
    launch(16'h8001, 16'h0001);
    chk_beats("recov", 1'b1, 16'h0003, 1'b1, 16'h0003, 1'b0);
    chk_idle("recov", 16'h0003);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule : tb_sru_step_scheduler
